// File: rtl/sie_scheduler_pkg.sv
// Shared PID constants, result codes, FSM states and response classification
// for the USB SIE transfer scheduler.
package sie_scheduler_pkg;

    localparam logic [7:0] PID_SETUP = 8'h2D;
    localparam logic [7:0] PID_OUT   = 8'hE1;
    localparam logic [7:0] PID_IN    = 8'h69;
    localparam logic [7:0] PID_SOF   = 8'hA5;
    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam logic [7:0] PID_NAK   = 8'h5A;
    localparam logic [7:0] PID_STALL = 8'h1E;
    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_DATA1 = 8'h4B;

    typedef enum logic [2:0] {
        RES_OK      = 3'd0,
        RES_NAK     = 3'd1,
        RES_STALL   = 3'd2,
        RES_TIMEOUT = 3'd3,
        RES_CRC     = 3'd4,
        RES_BADPID  = 3'd5
    } result_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SOF_GO,
        S_XFER_GO,
        S_WAIT_BUSY,
        S_WAIT_IDLE,
        S_EVAL,
        S_DONE
    } state_e;

    // Link errors outrank whatever PID happened to be captured.
    function automatic result_e classify(input logic timeout, input logic crc,
                                         input logic [7:0] pid);
        if (timeout) return RES_TIMEOUT;
        if (crc) return RES_CRC;
        case (pid)
            PID_ACK, PID_DATA0, PID_DATA1: return RES_OK;
            PID_NAK:                       return RES_NAK;
            PID_STALL:                     return RES_STALL;
            default:                       return RES_BADPID;
        endcase
    endfunction

endpackage

// File: rtl/sie_scheduler_frame_timer.sv
// 1 ms frame timer: down-counter with terminal-count reload and an 11-bit
// frame number that advances on every reload.
module usb_frame_timer #(
    parameter int FRAME_TICKS = 12000,
    parameter int TW          = 14
) (
    input  logic          clk_i,
    input  logic          rst_i,
    output logic          tick_o,
    output logic [TW-1:0] remaining_o,
    output logic [10:0]   frame_o
);

    localparam logic [TW-1:0] RELOAD = TW'(FRAME_TICKS - 1);

    logic [TW-1:0] rem_q, rem_d;
    logic [10:0]   frame_q, frame_d;

    assign tick_o      = (rem_q == '0);
    assign remaining_o = rem_q;
    assign frame_o     = frame_q;

    always_comb begin
        rem_d   = rem_q - TW'(1);
        frame_d = frame_q;
        if (tick_o) begin
            rem_d   = RELOAD;
            frame_d = frame_q + 11'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rem_q   <= RELOAD;
            frame_q <= '0;
        end else begin
            rem_q   <= rem_d;
            frame_q <= frame_d;
        end
    end

endmodule

// File: rtl/sie_scheduler.sv
// Host-side USB transfer scheduler: interleaves periodic SOF tokens with
// requester transfers, retries link errors and reports a result per transfer.
//
// state        | meaning
// S_IDLE       | waiting for SIE idle; SOF first, then held retry, then new request
// S_SOF_GO     | start pulse for an SOF token
// S_XFER_GO    | start pulse for the held transfer
// S_WAIT_BUSY  | one cycle for the SIE to drop idle
// S_WAIT_IDLE  | SIE busy with the token/transaction
// S_EVAL       | classify response, retry or finish
// S_DONE       | done pulse, results latched
module sie_scheduler
    import sie_scheduler_pkg::*;
#(
    parameter int FRAME_TICKS = 12000,
    parameter int GUARD_TICKS = 1000,
    parameter int MAX_RETRY   = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        sof_en_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [7:0]  req_pid_i,
    input  logic [6:0]  req_dev_i,
    input  logic [3:0]  req_ep_i,
    input  logic [15:0] req_len_i,
    input  logic        req_data1_i,
    output logic        done_o,
    output logic [2:0]  result_o,
    output logic [7:0]  resp_pid_o,
    output logic [15:0] rx_len_o,
    output logic [10:0] frame_o,
    output logic        start_o,
    output logic        in_transfer_o,
    output logic        sof_transfer_o,
    output logic        resp_expected_o,
    output logic [7:0]  token_pid_o,
    output logic [6:0]  token_dev_o,
    output logic [3:0]  token_ep_o,
    output logic [15:0] data_len_o,
    output logic        data_idx_o,
    input  logic        idle_i,
    input  logic        crc_err_i,
    input  logic        timeout_i,
    input  logic [7:0]  response_i,
    input  logic [15:0] rx_count_i
);

    localparam int TW = (FRAME_TICKS > 2) ? $clog2(FRAME_TICKS) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [TW-1:0] GUARD_W = TW'(GUARD_TICKS);
    localparam logic [RW-1:0] RETRY_W = RW'(MAX_RETRY);

    state_e        state_q, state_d;
    logic          tick;
    logic [TW-1:0] remaining;
    logic          guard_ok, accept, retry_now;
    result_e       eval_res;

    logic          sof_pend_q, held_q;
    logic [RW-1:0] retry_q;
    logic [7:0]    h_pid_q;
    logic [6:0]    h_dev_q;
    logic [3:0]    h_ep_q;
    logic [15:0]   h_len_q;
    logic          h_data1_q;

    logic [7:0]    src_pid;
    logic [6:0]    src_dev;
    logic [3:0]    src_ep;
    logic [15:0]   src_len;
    logic          src_data1;

    logic          start_q, in_q, sof_q, resp_exp_q, data_idx_q, done_q;
    logic [7:0]    tok_pid_q, resp_pid_q;
    logic [6:0]    tok_dev_q;
    logic [3:0]    tok_ep_q;
    logic [15:0]   data_len_q, rx_len_q;
    logic [2:0]    result_q;

    usb_frame_timer #(
        .FRAME_TICKS (FRAME_TICKS),
        .TW          (TW)
    ) u_frame_timer (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .tick_o      (tick),
        .remaining_o (remaining),
        .frame_o     (frame_o)
    );

    // A retry re-issues the held fields; a fresh accept issues straight from the port.
    assign src_pid   = held_q ? h_pid_q   : req_pid_i;
    assign src_dev   = held_q ? h_dev_q   : req_dev_i;
    assign src_ep    = held_q ? h_ep_q    : req_ep_i;
    assign src_len   = held_q ? h_len_q   : req_len_i;
    assign src_data1 = held_q ? h_data1_q : req_data1_i;

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        retry_now = 1'b0;
        guard_ok  = !sof_en_i || (remaining >= GUARD_W);
        eval_res  = classify(timeout_i, crc_err_i, response_i);
        case (state_q)
            S_IDLE: begin
                if (idle_i) begin
                    if (sof_pend_q) begin
                        state_d = S_SOF_GO;
                    end else if (held_q) begin
                        if (guard_ok) state_d = S_XFER_GO;
                    end else if (req_valid_i && guard_ok) begin
                        accept  = 1'b1;
                        state_d = S_XFER_GO;
                    end
                end
            end
            S_SOF_GO:    state_d = S_WAIT_BUSY;
            S_XFER_GO:   state_d = S_WAIT_BUSY;
            S_WAIT_BUSY: state_d = S_WAIT_IDLE;
            S_WAIT_IDLE: begin
                if (idle_i) state_d = sof_q ? S_IDLE : S_EVAL;
            end
            S_EVAL: begin
                if ((eval_res == RES_TIMEOUT || eval_res == RES_CRC) && retry_q < RETRY_W) begin
                    retry_now = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign req_ready_o = accept && !rst_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            sof_pend_q <= 1'b0;
            held_q     <= 1'b0;
            retry_q    <= '0;
            h_pid_q    <= '0;
            h_dev_q    <= '0;
            h_ep_q     <= '0;
            h_len_q    <= '0;
            h_data1_q  <= 1'b0;
            start_q    <= 1'b0;
            in_q       <= 1'b0;
            sof_q      <= 1'b0;
            resp_exp_q <= 1'b0;
            data_idx_q <= 1'b0;
            tok_pid_q  <= '0;
            tok_dev_q  <= '0;
            tok_ep_q   <= '0;
            data_len_q <= '0;
            done_q     <= 1'b0;
            result_q   <= '0;
            resp_pid_q <= '0;
            rx_len_q   <= '0;
        end else begin
            state_q <= state_d;
            start_q <= (state_d == S_SOF_GO) || (state_d == S_XFER_GO);
            done_q  <= (state_d == S_DONE);

            // A reload while an SOF is already pending folds into it.
            if (tick && sof_en_i) sof_pend_q <= 1'b1;
            else if (state_q == S_SOF_GO) sof_pend_q <= 1'b0;

            if (accept) begin
                held_q    <= 1'b1;
                h_pid_q   <= req_pid_i;
                h_dev_q   <= req_dev_i;
                h_ep_q    <= req_ep_i;
                h_len_q   <= req_len_i;
                h_data1_q <= req_data1_i;
            end

            if (state_q == S_IDLE && state_d == S_SOF_GO) begin
                tok_pid_q  <= PID_SOF;
                tok_dev_q  <= frame_o[6:0];
                tok_ep_q   <= frame_o[10:7];
                data_len_q <= '0;
                data_idx_q <= 1'b0;
                in_q       <= 1'b0;
                sof_q      <= 1'b1;
                resp_exp_q <= 1'b0;
            end else if (state_q == S_IDLE && state_d == S_XFER_GO) begin
                tok_pid_q  <= src_pid;
                tok_dev_q  <= src_dev;
                tok_ep_q   <= src_ep;
                data_len_q <= src_len;
                data_idx_q <= src_data1;
                in_q       <= (src_pid == PID_IN);
                sof_q      <= 1'b0;
                resp_exp_q <= 1'b1;
            end

            if (retry_now) retry_q <= retry_q + RW'(1);

            if (state_d == S_DONE) begin
                result_q   <= eval_res;
                resp_pid_q <= response_i;
                rx_len_q   <= rx_count_i;
            end

            if (state_q == S_DONE) begin
                retry_q <= '0;
                held_q  <= 1'b0;
            end
        end
    end

    assign start_o         = start_q;
    assign in_transfer_o   = in_q;
    assign sof_transfer_o  = sof_q;
    assign resp_expected_o = resp_exp_q;
    assign token_pid_o     = tok_pid_q;
    assign token_dev_o     = tok_dev_q;
    assign token_ep_o      = tok_ep_q;
    assign data_len_o      = data_len_q;
    assign data_idx_o      = data_idx_q;
    assign done_o          = done_q;
    assign result_o        = result_q;
    assign resp_pid_o      = resp_pid_q;
    assign rx_len_o        = rx_len_q;

endmodule

// File: tb/tb_sie_scheduler.sv
// Directed bench for sie_scheduler with a small behavioural SIE that answers
// each start after a configurable latency.
module tb_sie_scheduler;

    localparam int FT = 100;
    localparam int GT = 20;
    localparam int MR = 3;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        sof_en_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic [7:0]  req_pid_i = '0;
    logic [6:0]  req_dev_i = '0;
    logic [3:0]  req_ep_i = '0;
    logic [15:0] req_len_i = '0;
    logic        req_data1_i = 1'b0;
    logic        idle_i = 1'b1;
    logic        crc_err_i = 1'b0;
    logic        timeout_i = 1'b0;
    logic [7:0]  response_i = '0;
    logic [15:0] rx_count_i = '0;

    logic        req_ready_o, done_o, start_o, in_transfer_o, sof_transfer_o;
    logic        resp_expected_o, data_idx_o;
    logic [2:0]  result_o;
    logic [7:0]  resp_pid_o, token_pid_o;
    logic [15:0] rx_len_o, data_len_o;
    logic [10:0] frame_o;
    logic [6:0]  token_dev_o;
    logic [3:0]  token_ep_o;

    sie_scheduler #(.FRAME_TICKS(FT), .GUARD_TICKS(GT), .MAX_RETRY(MR)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .sof_en_i(sof_en_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_pid_i(req_pid_i), .req_dev_i(req_dev_i), .req_ep_i(req_ep_i),
        .req_len_i(req_len_i), .req_data1_i(req_data1_i),
        .done_o(done_o), .result_o(result_o), .resp_pid_o(resp_pid_o),
        .rx_len_o(rx_len_o), .frame_o(frame_o),
        .start_o(start_o), .in_transfer_o(in_transfer_o),
        .sof_transfer_o(sof_transfer_o), .resp_expected_o(resp_expected_o),
        .token_pid_o(token_pid_o), .token_dev_o(token_dev_o),
        .token_ep_o(token_ep_o), .data_len_o(data_len_o), .data_idx_o(data_idx_o),
        .idle_i(idle_i), .crc_err_i(crc_err_i), .timeout_i(timeout_i),
        .response_i(response_i), .rx_count_i(rx_count_i)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int lat = 5;
    int busy = 0;
    int n_sof = 0;
    int n_xfer = 0;
    int n_done = 0;
    int base = 0;
    int cfg_to = 0;
    int cfg_crc = 0;
    int att;
    logic [7:0]  cfg_resp = '0;
    logic [15:0] cfg_rx = '0;
    logic        last_sof = 1'b0;
    int          sof_cyc[8];
    logic [10:0] sof_tag[8];
    logic [7:0]  sof_pid[8];
    logic [7:0]  x_pid = '0;
    logic [6:0]  x_dev = '0;
    logic [3:0]  x_ep = '0;
    logic        x_in = 1'b0;
    logic        x_resp = 1'b0;
    logic [15:0] x_len = '0;

    always @(posedge clk_i) cyc++;

    // Behavioural SIE: goes busy on start, returns status after lat cycles.
    always @(negedge clk_i) begin
        if (rst_i) begin
            idle_i = 1'b1;
            busy = 0;
        end else begin
            if (done_o) n_done++;
            if (start_o) begin
                idle_i = 1'b0;
                busy = lat;
                last_sof = sof_transfer_o;
                if (sof_transfer_o) begin
                    if (n_sof < 8) begin
                        sof_cyc[n_sof] = cyc;
                        sof_tag[n_sof] = {token_ep_o, token_dev_o};
                        sof_pid[n_sof] = token_pid_o;
                    end
                    n_sof++;
                end else begin
                    n_xfer++;
                    x_pid = token_pid_o;
                    x_dev = token_dev_o;
                    x_ep = token_ep_o;
                    x_in = in_transfer_o;
                    x_resp = resp_expected_o;
                    x_len = data_len_o;
                end
            end else if (busy > 0) begin
                busy--;
                if (busy == 0) begin
                    idle_i = 1'b1;
                    if (!last_sof) begin
                        att = n_xfer - base;
                        timeout_i = (att <= cfg_to);
                        crc_err_i = !timeout_i && (att <= cfg_to + cfg_crc);
                        response_i = cfg_resp;
                        rx_count_i = cfg_rx;
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input logic [7:0] pid, input logic [6:0] dev, input logic [3:0] ep,
                           input logic [15:0] len, input logic [7:0] resp, input logic [15:0] rx,
                           input int to, input int crc);
        base = n_xfer;
        cfg_to = to;
        cfg_crc = crc;
        cfg_resp = resp;
        cfg_rx = rx;
        req_pid_i = pid;
        req_dev_i = dev;
        req_ep_i = ep;
        req_len_i = len;
        req_data1_i = 1'b0;
        req_valid_i = 1'b1;
    endtask

    task automatic wait_accept();
        logic got;
        got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            #1;
            if (req_ready_o) begin
                got = 1'b1;
                break;
            end
            @(negedge clk_i);
        end
        @(posedge clk_i);
        #1 req_valid_i = 1'b0;
        check("accept", 32'(got), 1);
    endtask

    task automatic wait_done();
        logic got;
        got = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk_i);
            if (done_o) begin
                got = 1'b1;
                break;
            end
        end
        check("done", 32'(got), 1);
    endtask

    task automatic run_xfer(input logic [7:0] pid, input logic [6:0] dev, input logic [3:0] ep,
                            input logic [15:0] len, input logic [7:0] resp, input logic [15:0] rx,
                            input int to, input int crc);
        @(negedge clk_i);
        set_req(pid, dev, ep, len, resp, rx, to, crc);
        wait_accept();
        wait_done();
    endtask

    int s0;

    initial begin
        repeat (3) @(negedge clk_i);
        check("rst_ctrl", 32'({start_o, done_o, req_ready_o, in_transfer_o, sof_transfer_o,
                               resp_expected_o, data_idx_o}), 0);
        check("rst_tok", 32'({token_pid_o, token_dev_o, token_ep_o}), 0);
        check("rst_frame", 32'(frame_o), 0);
        check("rst_res", 32'({result_o, resp_pid_o}), 0);
        rst_i = 1'b0;

        // Free-running SOFs
        for (int i = 0; i < 400 && n_sof < 3; i++) @(negedge clk_i);
        check("sof_count", 32'(n_sof), 3);
        for (int k = 0; k < 3; k++) begin
            check("sof_pid", 32'(sof_pid[k]), 'hA5);
            check("sof_frame", 32'(sof_tag[k]), k + 1);
        end
        check("sof_period1", 32'(sof_cyc[1] - sof_cyc[0]), FT);
        check("sof_period2", 32'(sof_cyc[2] - sof_cyc[1]), FT);
        check("sof_no_done", 32'(n_done), 0);

        // IN transfer answered with DATA0
        run_xfer(8'h69, 7'd5, 4'd1, 16'd0, 8'hC3, 16'd8, 0, 0);
        check("in_result", 32'(result_o), 0);
        check("in_resp", 32'(resp_pid_o), 'hC3);
        check("in_rx", 32'(rx_len_o), 8);
        check("in_token", 32'({x_pid, x_dev, x_ep}), 32'({8'h69, 7'd5, 4'd1}));
        check("in_flags", 32'({x_in, x_resp}), 3);

        // OUT transfer that times out every attempt
        run_xfer(8'hE1, 7'd9, 4'd2, 16'd64, 8'hD2, 16'd0, 4, 0);
        check("to_attempts", 32'(n_xfer - base), 4);
        check("to_result", 32'(result_o), 3);
        check("out_len", 32'({x_in, x_len}), 64);

        // One CRC error then ACK
        run_xfer(8'hE1, 7'd9, 4'd2, 16'd4, 8'hD2, 16'd0, 0, 1);
        check("crc_attempts", 32'(n_xfer - base), 2);
        check("crc_result", 32'(result_o), 0);

        // STALL and NAK are final, no retry
        run_xfer(8'h69, 7'd3, 4'd0, 16'd0, 8'h1E, 16'd0, 0, 0);
        check("stall_result", 32'(result_o), 2);
        check("stall_attempts", 32'(n_xfer - base), 1);
        run_xfer(8'h69, 7'd3, 4'd0, 16'd0, 8'h5A, 16'd0, 0, 0);
        check("nak_result", 32'(result_o), 1);
        run_xfer(8'h2D, 7'd3, 4'd0, 16'd8, 8'h00, 16'd0, 0, 0);
        check("bad_result", 32'(result_o), 5);

        // Request inside the guard window waits for the next SOF
        s0 = n_sof;
        for (int i = 0; i < 300 && n_sof == s0; i++) @(negedge clk_i);
        repeat (85) @(negedge clk_i);
        set_req(8'h69, 7'd7, 4'd3, 16'd0, 8'h4B, 16'd2, 0, 0);
        #1;
        check("guard_block", 32'(req_ready_o), 0);
        s0 = n_sof;
        wait_accept();
        check("guard_after_sof", 32'(n_sof - s0), 1);
        wait_done();
        check("guard_result", 32'({result_o, rx_len_o}), 32'({3'd0, 16'd2}));

        // Reset while the SIE is busy
        lat = 30;
        @(negedge clk_i);
        set_req(8'hE1, 7'd1, 4'd1, 16'd16, 8'hD2, 16'd0, 0, 0);
        s0 = n_xfer;
        wait_accept();
        for (int i = 0; i < 300 && n_xfer == s0; i++) @(negedge clk_i);
        repeat (5) @(negedge clk_i);
        check("busy_resp_exp", 32'(resp_expected_o), 1);
        rst_i = 1'b1;
        #1;
        check("rst_mid_ctrl", 32'({start_o, resp_expected_o, in_transfer_o, sof_transfer_o,
                                   req_ready_o, done_o}), 0);
        check("rst_mid_tok", 32'({token_pid_o, data_len_o}), 0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        lat = 5;
        @(negedge clk_i);
        check("rst_rel_frame", 32'(frame_o), 0);
        run_xfer(8'h69, 7'd2, 4'd2, 16'd0, 8'hD2, 16'd0, 0, 0);
        check("post_rst_result", 32'(result_o), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/sie_scheduler.md
SIE_SCHEDULER -- requirements
Module: sie_scheduler

Interface
REQ-001 Parameter FRAME_TICKS, default 12000, clk_i cycles per 1 ms USB frame.
REQ-002 Parameter GUARD_TICKS, default 1000, minimum frame-timer value required to start a new transfer.
REQ-003 Parameter MAX_RETRY, default 3, re-issues allowed after timeout or CRC error.
REQ-004 clk_i  in  1  single clock; all logic on posedge clk_i.
REQ-005 rst_i  in  1  reset, asynchronous, active-high.
REQ-006 sof_en_i  in  1  enable periodic SOF generation.
REQ-007 req_valid_i / req_ready_o  in/out  1/1  requester handshake; a transfer is accepted when both are high on one edge.
REQ-008 req_pid_i, req_dev_i, req_ep_i, req_len_i, req_data1_i  in  8/7/4/16/1  token PID (SETUP 2D, OUT E1, IN 69), address, endpoint, OUT length, DATA1 select.
REQ-009 done_o  out  1  one-cycle pulse when a transfer finishes.
REQ-010 result_o, resp_pid_o, rx_len_o  out  3/8/16  result code, last response PID, received byte count; all held until the next done_o.
REQ-011 frame_o  out  11  current frame number.
REQ-012 SIE control outputs: start_o, in_transfer_o, sof_transfer_o, resp_expected_o (1 each), token_pid_o 8, token_dev_o 7, token_ep_o 4, data_len_o 16, data_idx_o 1.
REQ-013 SIE status inputs: idle_i, crc_err_i, timeout_i (1 each), response_i 8, rx_count_i 16.

Function
REQ-014 Frame timer counts down from FRAME_TICKS-1 to 0 and reloads; on reload, frame_o increments modulo 2048 and sof_pend is set if sof_en_i=1.
REQ-015 States: S_IDLE, S_SOF_GO, S_XFER_GO, S_WAIT_BUSY, S_WAIT_IDLE, S_EVAL, S_DONE.
REQ-016 S_IDLE with idle_i=1: sof_pend has priority -> S_SOF_GO; else if req_valid_i and (sof_en_i=0 or frame timer >= GUARD_TICKS), the request is accepted -> S_XFER_GO.
REQ-017 req_ready_o is high only in S_IDLE when the REQ-016 acceptance condition holds and sof_pend=0; request fields are latched at acceptance.
REQ-018 S_SOF_GO: start_o=1 for exactly one cycle, sof_transfer_o=1, token_pid_o=A5, token_dev_o=frame_o[6:0], token_ep_o=frame_o[10:7], resp_expected_o=0; sof_pend clears; -> S_WAIT_BUSY.
REQ-019 S_XFER_GO: start_o=1 for one cycle with the latched fields; in_transfer_o=(pid==69); resp_expected_o=1; sof_transfer_o=0; -> S_WAIT_BUSY.
REQ-020 S_WAIT_BUSY lasts one cycle, then -> S_WAIT_IDLE; S_WAIT_IDLE holds until idle_i=1.
REQ-021 On SIE idle after an SOF -> S_IDLE with no done_o; after a transfer -> S_EVAL.
REQ-022 S_EVAL result codes, in priority order: timeout_i -> 3 TIMEOUT; crc_err_i -> 4 CRC; response D2, C3 or 4B -> 0 OK; 5A -> 1 NAK; 1E -> 2 STALL; otherwise 5 BADPID.
REQ-023 For TIMEOUT or CRC with retry_cnt < MAX_RETRY: retry_cnt increments and the transfer re-queues (-> S_IDLE with the request still held, req_ready_o=0); otherwise -> S_DONE.
REQ-024 S_DONE: done_o=1 for one cycle; result_o, resp_pid_o=response_i, rx_len_o=rx_count_i are latched; retry_cnt clears; -> S_IDLE.
REQ-025 A held retry takes precedence over new requests and obeys the REQ-016 guard and SOF priority.
REQ-026 A frame reload during an in-flight transfer only sets sof_pend; the transfer is never aborted.
REQ-027 sof_pend set while already pending stays set; at most one SOF is pending.
REQ-028 Control outputs are registered and held stable from start_o until S_WAIT_IDLE exits.

Reset
REQ-029 rst_i=1 asynchronously forces: S_IDLE, all outputs 0, frame timer FRAME_TICKS-1, frame_o 0, sof_pend 0, retry_cnt 0, held request discarded.
REQ-030 Reset mid-transfer requires no SIE handshake; the SIE is reset from the same rst_i.

Structure
REQ-031 The shared package holds PID constants (SETUP, OUT, IN, SOF, ACK, NAK, STALL, DATA0, DATA1) and result codes 0-5.
REQ-032 The frame timer and frame counter form one sub-module, usb_frame_timer (outputs: tick, remaining, frame).

Verification
REQ-033 FRAME_TICKS=100, sof_en_i=1, no requests -> start_o with token_pid_o=A5 every 100 cycles; token_dev_o/ep_o match frame 1, 2, 3; no done_o.
REQ-034 IN request dev 5 ep 1; SIE model returns C3 with rx_count 8 -> done_o, result_o=0, resp_pid_o=C3, rx_len_o=8.
REQ-035 OUT request; SIE model times out 4 times -> 4 start_o pulses, then done_o with result_o=3.
REQ-036 Request asserted when frame timer < GUARD_TICKS -> req_ready_o=0 until after the next SOF is issued, then accepted.
REQ-037 Response 1E -> result_o=2 with no retry; response 5A -> result_o=1.
REQ-038 rst_i asserted while in S_WAIT_IDLE -> all outputs 0 immediately; frame_o=0 after release.
